channel_mux: RTL and testbench
==============================

# channel_mux

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshaking on every input and on the output. Operates in one of two modes: manual (an external select picks the source) or round-robin (an internal arbiter rotates fairly across requesting channels). It is the clocked, flow-controlled successor to the team's 4:1 combinational multiplexer. It sits between multiple producers and a single downstream consumer.

## Interface
- `WIDTH`, 4: data bits per channel (≥1)
- `CHANNELS`, 4: number of input channels (≥2)
- `SEL_W`, derived localparam: `$clog2(CHANNELS)`
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `in_valid`  in  CHANNELS  per-channel request
- `in_ready`  out  CHANNELS  per-channel accept; at most one bit high per cycle
- `mode`  in  1  0 = manual, 1 = round-robin
- `sel`  in  SEL_W  source channel in manual mode; ignored in RR mode
- `out_data`  out  WIDTH  registered data
- `out_chan`  out  SEL_W  channel index that supplied `out_data`
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  downstream accept

## Operation
- Single output register: `out_data`, `out_chan`, `out_valid`.
- `load = !out_valid || out_ready`. The register can take a new word this cycle.
- Grant g is chosen combinationally:
  - **Manual:** g = `sel` if `sel < CHANNELS` and `in_valid[sel]`; otherwise no grant. `sel ≥ CHANNELS` never grants.
  - **RR:** g is the first k with `in_valid[k]`, scanning from `ptr+1` upward and wrapping modulo CHANNELS. `ptr` is the last RR-granted channel.
- `in_ready[g] = load` when a grant exists. All other `in_ready` bits are 0.
- A transfer occurs on an input when `in_valid && in_ready`. At that edge the register loads `in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
- Drain without refill: if `out_valid && out_ready` and there is no grant, then `out_valid <= 0`. `out_data` and `out_chan` hold their last value.
- `ptr` updates to g only on RR-mode transfers. Manual-mode transfers leave `ptr` unchanged.
- Stall: while `out_valid && !out_ready`, all `in_ready` are 0. Output fields stay stable, with no change on any input.
- Mode or `sel` change is sampled every cycle. It affects only the next grant; a held output word is unaffected.
- No data is ever dropped or duplicated. A word is emitted exactly once per input transfer.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=CHANNELS-1` (first RR grant favours channel 0). `in_ready` is 0 during reset.
- Reset asserted mid-stream discards the held word on the next edge.
- Latency: input transfer at edge t makes the word visible on `out_*` after edge t.
- Throughput: one word per cycle while `out_ready` is held high and requests exist. There are no bubbles on back-to-back transfers.
- Combinational paths:
  - `in_valid`/`sel`/`mode`/`out_ready` → `in_ready` exists. This is required.
  - There is no combinational path from inputs to `out_*`.
- Wrap-around: with `ptr = CHANNELS-1`, the scan starts at 0.
- Single requester in RR: granted every cycle regardless of `ptr`.

## Structure
- Shared package `mux_pkg`:
  - `MODE_MANUAL = 1'b0`, `MODE_RR = 1'b1`
  - a default-width localparam set reused by benches
- Sub-module `rr_arbiter` (parameter `N`):
  - inputs `req[N]`, `ptr`
  - outputs `gnt_valid`, `gnt_idx`
  - purely combinational rotate-priority search
- `ptr`, the output register, and the mode mux stay in `channel_mux`.
- Expected size: about 150–250 lines total.

## Test plan
All scenarios use `WIDTH=4`, `CHANNELS=4`.
- **Reset and manual mode:** hold `rst` 2 cycles, then `mode=0`, `sel=2`, `in_valid=4'b0100`, `in_data[2]=4'hA`, `out_ready=1` → `in_ready=4'b0100`; next cycle `out_valid=1`, `out_data=A`, `out_chan=2`. All outputs are 0 during reset.
- **Exhaustive manual sweep:** for every `in_data` pattern 0–15 on all channels and `sel=0..3` → `out_data` equals the selected channel's data one cycle later; the unselected channel's `in_ready` stays 0.
- **RR fairness:** `mode=1`, `in_valid=4'b1111`, channel data 1,2,3,4, `out_ready=1` for 8 cycles → `out_chan` sequence 0,1,2,3,0,1,2,3 and data 1,2,3,4,1,2,3,4.
- **Sparse and wrapping RR:** `in_valid=4'b1001` with `ptr=3` after reset → grants alternate 0,3,0,3. Then `in_valid=4'b0010` → grant is 1 every cycle.
- **Backpressure:** load a word, then hold `out_ready=0` for 3 cycles with all `in_valid` high → `in_ready=0` and `out_*` stable. Then raise `out_ready` → the held word leaves and a new word loads on the same edge.
- **Reset mid-operation:** assert `rst` while `out_valid=1` and `out_ready=0` → after the edge, `out_valid=0` and `out_chan=0`; the next RR grant is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the channel multiplexer: mode encoding and the
// default geometry used by the top and its benches.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first requester strictly after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic [IW-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    // i runs 1..N so the last-granted channel is visited last.
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/channel_mux.sv
// Registered N-to-1 channel multiplexer with valid/ready on every port,
// selectable between an external select and a round-robin arbiter.
module channel_mux
  import mux_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Valid vector padded to the full select range so out-of-range selects
  // land on a constant zero instead of needing a compare.
  localparam int PAD_W = (1 << SEL_W) + 1;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             rr_gnt_valid;
  logic [SEL_W-1:0] rr_gnt_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [PAD_W-1:0] valid_pad;

  assign load      = !out_valid_q || out_ready;
  assign valid_pad = PAD_W'(in_valid);

  rr_arbiter #(.N(CHANNELS)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_gnt_valid),
    .gnt_idx   (rr_gnt_idx)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (mode == MODE_RR) begin
      gnt_valid = rr_gnt_valid;
      gnt_idx   = rr_gnt_idx;
    end else begin
      gnt_valid = valid_pad[{1'b0, sel}];
      gnt_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load && gnt_valid) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_valid) begin
        out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_chan_d  = gnt_idx;
        out_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = gnt_idx;
        end
      end else begin
        // Drain: data and channel keep their last value.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_channel_mux.sv
// Directed bench for channel_mux: a small reference model predicts grants and
// pushes each accepted word to a scoreboard that is checked as it drains.
module tb_channel_mux;
  import mux_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int C = DEF_CHANNELS;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_valid = '0;
  logic [C-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [1:0]     sel = '0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_chan;
  logic           out_valid;
  logic           out_ready = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   chan;
  } word_t;

  word_t sb[$];
  int total  = 0;
  int passed = 0;

  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic [1:0]   m_chan  = '0;
  logic [1:0]   m_ptr   = 2'd3;

  channel_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  // Compare at the falling edge, predict the coming rising edge, then return
  // just after it so the caller can drive the next inputs.
  task automatic tick();
    logic         ld;
    logic         gv;
    logic [1:0]   g;
    logic [1:0]   k;
    logic [C-1:0] er;
    word_t        w;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_chan", 32'(out_chan), 32'(m_chan));
    if (m_valid && sb.size() > 0) begin
      check("sb_data", 32'(out_data), 32'(sb[0].data));
      check("sb_chan", 32'(out_chan), 32'(sb[0].chan));
    end
    if (rst) begin
      check("in_ready_rst", 32'(in_ready), 32'(0));
      sb.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = '0;
      m_ptr   = 2'd3;
    end else begin
      ld = !m_valid || out_ready;
      gv = 1'b0;
      g  = '0;
      if (mode == MODE_RR) begin
        for (int i = 1; i <= C; i++) begin
          k = 2'((int'(m_ptr) + i) % C);
          if (!gv && in_valid[k]) begin
            gv = 1'b1;
            g  = k;
          end
        end
      end else begin
        gv = in_valid[sel];
        g  = sel;
      end
      er = (ld && gv) ? (C'(1) << g) : '0;
      check("in_ready", 32'(in_ready), 32'(er));
      if (m_valid && out_ready) void'(sb.pop_front());
      if (ld && gv) begin
        w.data = in_data[int'(g)*W +: W];
        w.chan = g;
        sb.push_back(w);
        m_valid = 1'b1;
        m_data  = w.data;
        m_chan  = g;
        if (mode == MODE_RR) m_ptr = g;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sparse_exp[4];
    sparse_exp = '{2'd0, 2'd3, 2'd0, 2'd3};

    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();

    // Manual select of channel 2.
    rst = 1'b0;
    mode = MODE_MANUAL;
    sel = 2'd2;
    in_valid = 4'b0100;
    set_data(4'h0, 4'h0, 4'hA, 4'h0);
    out_ready = 1'b1;
    tick();
    check("man_valid", 32'(out_valid), 32'(1));
    check("man_data", 32'(out_data), 32'hA);
    check("man_chan", 32'(out_chan), 32'(2));
    in_valid = '0;
    tick();

    // Manual sweep: each channel carries a distinct value.
    in_valid = '1;
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        set_data(W'(d), W'(d + 1), W'(d + 2), W'(d + 3));
        tick();
        check("sweep_data", 32'(out_data), 32'((d + s) % 16));
      end
    end
    in_valid = '0;
    tick();

    // Round-robin fairness with every channel requesting.
    mode = MODE_RR;
    in_valid = 4'b1111;
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rr_chan", 32'(out_chan), 32'(i % 4));
      check("rr_data", 32'(out_data), 32'(i % 4 + 1));
    end
    in_valid = '0;
    tick();

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Sparse requesters across the wrap point, then a single requester.
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_sparse", 32'(out_chan), 32'(sparse_exp[i]));
    end
    in_valid = 4'b0010;
    set_data(4'd5, 4'd6, 4'd7, 4'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_single", 32'(out_chan), 32'(1));
    end

    // Backpressure: hold the word, then release with a same-edge refill.
    in_valid = 4'b1111;
    set_data(4'h9, 4'hB, 4'hC, 4'hD);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();
    check("stall_data", 32'(out_data), 32'hC);
    out_ready = 1'b1;
    tick();
    check("refill_chan", 32'(out_chan), 32'(3));
    tick();

    // Reset while a word is held under backpressure.
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'(0));
    check("rst_mid_chan", 32'(out_chan), 32'(0));
    rst = 1'b0;
    mode = MODE_RR;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    tick();
    check("post_rst_chan", 32'(out_chan), 32'(0));
    in_valid = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
